puf_eval_ctrl: RTL and testbench
================================

PUF_EVAL_CTRL -- requirements
Module: puf_eval_ctrl

Interface
REQ-001 Parameter WINDOW_CYCLES, default 255: number of cycles puf_en is held high per challenge, range 1..1023.
REQ-002 Parameter CLEAR_CYCLES, default 2: number of cycles puf_reset is held high before each measurement, minimum 1.
REQ-003 Parameter SETTLE_CYCLES, default 3: number of idle cycles between the puf_en fall and the response capture, minimum 1.
REQ-004 Parameter NUM_CHAL, default 16: number of challenges per run, range 1..16.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  sampled only in IDLE; a high level begins a run.
REQ-008 abort  in  1  terminates any active run.
REQ-009 seed  in  10  initial challenge for the LFSR.
REQ-010 response  in  8  PUF comparator output; stable after puf_en falls.
REQ-011 resp_ready  in  1  consumer ready.
REQ-012 puf_en  out  1  ring-oscillator enable to the PUF.
REQ-013 puf_reset  out  1  PUF counter clear.
REQ-014 challenge  out  10  challenge to the PUF; bits [4:0] go to bank A, bits [9:5] to bank B.
REQ-015 resp_valid, resp_data[7:0], resp_chal[9:0], resp_idx[3:0]  out  --  response record with valid/ready handshake.
REQ-016 busy  out  1  high in every state other than IDLE.
REQ-017 done  out  1  one-cycle pulse at the normal end of a run.

Function
REQ-018 FSM states SHALL be IDLE, CLEAR, MEASURE, SETTLE, CAPTURE and OUTPUT; all outputs SHALL be registered.
REQ-019 IDLE with start=1 SHALL load challenge=seed, or 10'h001 if seed==0, set idx=0, and enter CLEAR.
REQ-020 CLEAR SHALL drive puf_reset=1 and puf_en=0 for exactly CLEAR_CYCLES cycles, then enter MEASURE.
REQ-021 MEASURE SHALL drive puf_en=1 and puf_reset=0 for exactly WINDOW_CYCLES cycles, then enter SETTLE.
REQ-022 SETTLE SHALL drive puf_en=0 and puf_reset=0 for SETTLE_CYCLES cycles, then enter CAPTURE.
REQ-023 CAPTURE SHALL, in one cycle, register resp_data=response, resp_chal=challenge and resp_idx=idx, then enter OUTPUT with resp_valid=1.
REQ-024 resp_valid SHALL first be high CLEAR_CYCLES+WINDOW_CYCLES+SETTLE_CYCLES+1 cycles after the edge that samples start.
REQ-025 In OUTPUT, resp_valid and all record fields SHALL stay stable until a cycle where resp_valid&&resp_ready is true.
REQ-026 On that handshake, resp_valid SHALL fall on the next cycle.
REQ-027 On a handshake with idx==NUM_CHAL-1: done=1 for one cycle, then IDLE.
REQ-028 On any other handshake: idx+1, challenge advances one LFSR step, then CLEAR.
REQ-029 The LFSR step SHALL be challenge<={challenge[8:0], challenge[9]^challenge[6]} (x^10+x^7+1); the all-zero state is unreachable.
REQ-030 The challenge output SHALL hold constant from CLEAR entry through OUTPUT exit.
REQ-031 start SHALL be ignored when the FSM is not in IDLE.
REQ-032 abort=1 in any non-IDLE state SHALL return the FSM to IDLE next cycle with puf_en, puf_reset, resp_valid and busy all 0.
REQ-033 An abort SHALL not produce a done pulse.
REQ-034 abort coinciding with a handshake: the transfer counts as completed, then the FSM goes to IDLE without done.
REQ-035 abort in IDLE SHALL have no effect.
REQ-036 abort and start both high in IDLE: start SHALL win.
REQ-037 Cycle counters SHALL be 10 bits wide and SHALL reload at each state entry.

Reset
REQ-038 When reset=1 at a clk edge: state=IDLE and puf_en, puf_reset, resp_valid, busy and done=0.
REQ-039 The same reset SHALL set resp_data=0, resp_chal=0, resp_idx=0, challenge=0 and idx=0.
REQ-040 Reset SHALL override start and abort.
REQ-041 Reset mid-run SHALL discard the run without emitting any record.

Structure
REQ-042 Package puf_pkg SHALL hold the state enum, the LFSR tap constants, the zero-seed substitute 10'h001 and the default parameter values.
REQ-043 The LFSR SHALL be a sub-module puf_lfsr10 with ports clk, reset, load, load_val, step and q.
REQ-044 The FSM and cycle counters SHALL live in puf_eval_ctrl.

Verification
REQ-045 seed=10'h2A5, W=8, C=2, S=3, N=1, resp_ready=1, response=8'h5C -> puf_reset high 2 cycles, puf_en high 8 cycles, resp_valid at cycle 14 with data 8'h5C, chal 10'h2A5, idx 0, and done one cycle after the handshake.
REQ-046 seed=0, N=3 -> resp_chal values 10'h001, 10'h002, 10'h004 with idx 0, 1, 2, followed by a single done pulse.
REQ-047 resp_ready low for 20 cycles in OUTPUT, response changed meanwhile -> resp_valid held with resp_data unchanged; advance occurs only after resp_ready rises.
REQ-048 abort in MEASURE cycle 4 -> next cycle puf_en=0, busy=0, no resp_valid and no done; a later start restarts from the seed.
REQ-049 reset during SETTLE, and start pulsed while busy -> every output zero after reset; the start pulsed while busy is ignored with no second run.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF evaluation controller.
package puf_pkg;

    localparam int unsigned CHAL_W = 10;
    localparam int unsigned RESP_W = 8;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CNT_W  = 10;

    localparam int unsigned DEF_WINDOW_CYCLES = 255;
    localparam int unsigned DEF_CLEAR_CYCLES  = 2;
    localparam int unsigned DEF_SETTLE_CYCLES = 3;
    localparam int unsigned DEF_NUM_CHAL      = 16;

    // x^10 + x^7 + 1: feedback from bits 9 and 6
    localparam int unsigned LFSR_TAP_A = 9;
    localparam int unsigned LFSR_TAP_B = 6;

    // All-zero is the LFSR lock-up state, so a zero seed is replaced
    localparam logic [CHAL_W-1:0] SEED_ZERO_SUB = 10'h001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_MEASURE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_OUTPUT
    } puf_state_e;

endpackage

// File: rtl/puf_eval_ctrl_if.sv
// Response record channel with valid/ready handshake.
interface puf_eval_ctrl_if;

    logic                        resp_valid;
    logic                        resp_ready;
    logic [puf_pkg::RESP_W-1:0]  resp_data;
    logic [puf_pkg::CHAL_W-1:0]  resp_chal;
    logic [puf_pkg::IDX_W-1:0]   resp_idx;

    modport master (
        output resp_valid,
        output resp_data,
        output resp_chal,
        output resp_idx,
        input  resp_ready
    );

    modport slave (
        input  resp_valid,
        input  resp_data,
        input  resp_chal,
        input  resp_idx,
        output resp_ready
    );

endinterface

// File: rtl/puf_lfsr10.sv
// 10-bit Fibonacci LFSR holding the current challenge.
module puf_lfsr10
    import puf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [CHAL_W-1:0] load_val,
    input  logic              step,
    output logic [CHAL_W-1:0] q
);

    // Load has priority over step; reset clears to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (step) begin
            q <= {q[CHAL_W-2:0], q[LFSR_TAP_A] ^ q[LFSR_TAP_B]};
        end
    end

endmodule

// File: rtl/puf_eval_ctrl.sv
// Sequences clear / measure / settle / capture for each challenge and
// hands the response records out over a valid/ready channel.
module puf_eval_ctrl #(
    parameter int unsigned WINDOW_CYCLES = puf_pkg::DEF_WINDOW_CYCLES,
    parameter int unsigned CLEAR_CYCLES  = puf_pkg::DEF_CLEAR_CYCLES,
    parameter int unsigned SETTLE_CYCLES = puf_pkg::DEF_SETTLE_CYCLES,
    parameter int unsigned NUM_CHAL      = puf_pkg::DEF_NUM_CHAL
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [puf_pkg::CHAL_W-1:0] seed,
    input  logic [puf_pkg::RESP_W-1:0] response,
    output logic                       puf_en,
    output logic                       puf_reset,
    output logic [puf_pkg::CHAL_W-1:0] challenge,
    output logic                       busy,
    output logic                       done,
    puf_eval_ctrl_if.master            resp_if
);

    import puf_pkg::*;

    localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHAL - 1);

    puf_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;

    logic              handshake_c;
    logic              lfsr_load_c;
    logic              lfsr_step_c;
    logic [CHAL_W-1:0] lfsr_seed_c;

    // LFSR control: load on run start, step when advancing to the next challenge
    always_comb begin
        handshake_c = resp_if.resp_valid && resp_if.resp_ready;
        lfsr_load_c = (state == ST_IDLE) && start;
        lfsr_step_c = (state == ST_OUTPUT) && handshake_c && !abort && (idx != LAST_IDX);
        lfsr_seed_c = (seed == '0) ? SEED_ZERO_SUB : seed;
    end

    puf_lfsr10 u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (lfsr_load_c),
        .load_val (lfsr_seed_c),
        .step     (lfsr_step_c),
        .q        (challenge)
    );

    // Main FSM with per-state cycle counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            idx                <= '0;
            puf_en             <= 1'b0;
            puf_reset          <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            resp_if.resp_valid <= 1'b0;
            resp_if.resp_data  <= '0;
            resp_if.resp_chal  <= '0;
            resp_if.resp_idx   <= '0;
        end else begin
            done <= 1'b0;
            if (abort && (state != ST_IDLE)) begin
                // Abort wins over everything except reset; a coinciding
                // handshake still completes because valid simply drops here
                state              <= ST_IDLE;
                puf_en             <= 1'b0;
                puf_reset          <= 1'b0;
                busy               <= 1'b0;
                resp_if.resp_valid <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state     <= ST_CLEAR;
                            cnt       <= CLR_LOAD;
                            idx       <= '0;
                            puf_reset <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    ST_CLEAR: begin
                        if (cnt == '0) begin
                            state     <= ST_MEASURE;
                            cnt       <= WIN_LOAD;
                            puf_reset <= 1'b0;
                            puf_en    <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_MEASURE: begin
                        if (cnt == '0) begin
                            state  <= ST_SETTLE;
                            cnt    <= SET_LOAD;
                            puf_en <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt == '0) begin
                            state <= ST_CAPTURE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_CAPTURE: begin
                        state              <= ST_OUTPUT;
                        resp_if.resp_data  <= response;
                        resp_if.resp_chal  <= challenge;
                        resp_if.resp_idx   <= idx;
                        resp_if.resp_valid <= 1'b1;
                    end
                    ST_OUTPUT: begin
                        if (handshake_c) begin
                            resp_if.resp_valid <= 1'b0;
                            if (idx == LAST_IDX) begin
                                state <= ST_IDLE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state     <= ST_CLEAR;
                                cnt       <= CLR_LOAD;
                                idx       <= idx + IDX_W'(1);
                                puf_reset <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Scoreboard bench for puf_eval_ctrl: W=8, C=2, S=3, N=3.
module tb_puf_eval_ctrl;

    localparam int unsigned W = 8;
    localparam int unsigned C = 2;
    localparam int unsigned S = 3;
    localparam int unsigned N = 3;

    typedef struct packed {
        logic [7:0] data;
        logic [9:0] chal;
        logic [3:0] idx;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       resp_ready;
    logic [9:0] seed;
    logic [7:0] response;
    logic       puf_en;
    logic       puf_reset;
    logic [9:0] challenge;
    logic       busy;
    logic       done;

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic exp_done_next = 1'b0;

    puf_eval_ctrl_if rif ();
    assign rif.resp_ready = resp_ready;

    puf_eval_ctrl #(
        .WINDOW_CYCLES (W),
        .CLEAR_CYCLES  (C),
        .SETTLE_CYCLES (S),
        .NUM_CHAL      (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .seed      (seed),
        .response  (response),
        .puf_en    (puf_en),
        .puf_reset (puf_reset),
        .challenge (challenge),
        .busy      (busy),
        .done      (done),
        .resp_if   (rif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks done timing
    always @(negedge clk) begin
        rec_t r;
        logic last_hs;
        #1;
        last_hs = 1'b0;
        if (done || exp_done_next)
            check("done_pulse", 32'(done), 32'(exp_done_next));
        if (rif.resp_valid && resp_ready && !reset) begin
            if (exp_q.size() == 0) begin
                check("record_expected", 32'd0, 32'd1);
            end else begin
                r = exp_q.pop_front();
                check("resp_data", 32'(rif.resp_data), 32'(r.data));
                check("resp_chal", 32'(rif.resp_chal), 32'(r.chal));
                check("resp_idx",  32'(rif.resp_idx),  32'(r.idx));
                last_hs = (r.idx == 4'(N - 1)) && !abort;
            end
        end
        exp_done_next = last_hs;
    end

    task automatic push(input logic [7:0] d, input logic [9:0] c, input logic [3:0] i);
        rec_t r;
        r.data = d; r.chal = c; r.idx = i;
        exp_q.push_back(r);
    endtask

    task automatic pulse_start(input logic [9:0] s, input logic with_abort);
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        abort = with_abort;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(input int max);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    // sel 0 watches puf_en, otherwise resp_valid
    task automatic wait_until(input int sel, input logic lvl, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            hit = (sel == 0) ? (puf_en == lvl) : (rif.resp_valid == lvl);
        end
        check(name, 32'(hit), 32'd1);
    endtask

    task automatic idle_window(input int cycles, input string name);
        int hi = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (busy || rif.resp_valid || puf_en || puf_reset) hi++;
        end
        check(name, 32'(hi), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rst_hi;
        int en_hi;
        int vcyc;

        reset = 1'b1; start = 1'b1; abort = 1'b1;
        resp_ready = 1'b1; seed = 10'h2A5; response = 8'h5C;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 32'({puf_en, puf_reset, busy, done, rif.resp_valid}), 32'd0);
        check("reset_rec", 32'({rif.resp_data, rif.resp_chal, rif.resp_idx}), 32'd0);
        check("reset_chal", 32'(challenge), 32'd0);
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        @(negedge clk);

        // Basic run: phase timing on the first record
        push(8'h5C, 10'h2A5, 4'd0);
        push(8'h5C, 10'h14B, 4'd1);
        push(8'h5C, 10'h297, 4'd2);
        pulse_start(10'h2A5, 1'b0);
        check("chal_loaded", 32'(challenge), 32'h2A5);
        rst_hi = 0; en_hi = 0; vcyc = -1;
        for (int k = 0; k < 60 && vcyc < 0; k++) begin
            if (k > 0) @(negedge clk);
            if (puf_reset) rst_hi++;
            if (puf_en) en_hi++;
            if (rif.resp_valid) vcyc = k;
        end
        check("puf_reset_cycles", 32'(rst_hi), 32'(C));
        check("puf_en_cycles", 32'(en_hi), 32'(W));
        check("first_valid_cycle", 32'(vcyc), 32'd14);
        wait_done(200);
        check("sb_empty_a", 32'(exp_q.size()), 32'd0);

        // Zero seed substitute, with a start pulse while busy that must be ignored
        response = 8'h77;
        push(8'h77, 10'h001, 4'd0);
        push(8'h77, 10'h002, 4'd1);
        push(8'h77, 10'h004, 4'd2);
        pulse_start(10'h000, 1'b0);
        repeat (5) @(negedge clk);
        pulse_start(10'h3FF, 1'b0);
        wait_done(200);
        idle_window(30, "no_second_run");
        check("sb_empty_b", 32'(exp_q.size()), 32'd0);

        // Consumer back-pressure on the first record
        resp_ready = 1'b0;
        response   = 8'hA1;
        push(8'hA1, 10'h3FF, 4'd0);
        push(8'h3E, 10'h3FE, 4'd1);
        push(8'h3E, 10'h3FC, 4'd2);
        pulse_start(10'h3FF, 1'b0);
        wait_until(1, 1'b1, "stall_valid_seen");
        response = 8'h3E;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_hold",
                  32'({rif.resp_valid, rif.resp_data, rif.resp_chal, rif.resp_idx, puf_reset}),
                  32'({1'b1, 8'hA1, 10'h3FF, 4'd0, 1'b0}));
        end
        resp_ready = 1'b1;
        wait_done(200);
        check("sb_empty_c", 32'(exp_q.size()), 32'd0);

        // Abort in measure cycle 4, abort in idle, then start+abort together
        response = 8'h5C;
        pulse_start(10'h2A5, 1'b0);
        wait_until(0, 1'b1, "measure_entered");
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_outputs", 32'({puf_en, puf_reset, busy, rif.resp_valid, done}), 32'd0);
        idle_window(20, "after_abort_quiet");
        abort = 1'b1;
        idle_window(5, "abort_in_idle");
        abort = 1'b0;
        push(8'h5C, 10'h2A5, 4'd0);
        push(8'h5C, 10'h14B, 4'd1);
        push(8'h5C, 10'h297, 4'd2);
        pulse_start(10'h2A5, 1'b1);
        check("start_beats_abort", 32'({busy, puf_reset}), 32'b11);
        check("restart_chal", 32'(challenge), 32'h2A5);
        wait_done(200);
        check("sb_empty_d", 32'(exp_q.size()), 32'd0);

        // Reset during settle discards the run
        pulse_start(10'h001, 1'b0);
        wait_until(0, 1'b1, "measure_entered_e");
        wait_until(0, 1'b0, "settle_entered_e");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrun_reset_ctrl", 32'({puf_en, puf_reset, busy, done, rif.resp_valid}), 32'd0);
        check("midrun_reset_rec", 32'({rif.resp_data, rif.resp_chal, rif.resp_idx}), 32'd0);
        check("midrun_reset_chal", 32'(challenge), 32'd0);
        idle_window(30, "after_reset_quiet");
        check("sb_empty_e", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
